// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: control bundle width, register index width, x0
package cpu_pkg;

    localparam int CTRL_W = 16;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode, register-file, writeback and execute signals around the ID/EX stage
interface id_ex_stage_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic              id_valid;
    logic [WIDTH-1:0]  id_pc;
    reg_addr_t         id_rs1_addr;
    reg_addr_t         id_rs2_addr;
    reg_addr_t         id_rd_addr;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              id_mem_read;
    logic [WIDTH-1:0]  id_imm;
    logic [CTRL_W-1:0] id_ctrl;

    reg_addr_t         rf_rs1_addr;
    reg_addr_t         rf_rs2_addr;
    logic [WIDTH-1:0]  rf_rs1_data;
    logic [WIDTH-1:0]  rf_rs2_data;

    logic              wb_regWrite;
    reg_addr_t         wb_rd_addr;
    logic [WIDTH-1:0]  wb_write_data;

    logic              ex_stall;
    logic              flush;

    logic              ex_valid;
    logic [WIDTH-1:0]  ex_pc;
    logic [WIDTH-1:0]  ex_rs1_data;
    logic [WIDTH-1:0]  ex_rs2_data;
    reg_addr_t         ex_rd_addr;
    logic [WIDTH-1:0]  ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;

    logic              stall_id;
    logic [31:0]       perf_stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_uses_rs1, id_uses_rs2, id_mem_read, id_imm, id_ctrl,
               rf_rs1_data, rf_rs2_data, wb_regWrite, wb_rd_addr, wb_write_data,
               ex_stall, flush,
        input  rf_rs1_addr, rf_rs2_addr, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_rd_addr, ex_imm, ex_ctrl, ex_mem_read, stall_id, perf_stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_uses_rs1, id_uses_rs2, id_mem_read, id_imm, id_ctrl,
               rf_rs1_data, rf_rs2_data, wb_regWrite, wb_rd_addr, wb_write_data,
               ex_stall, flush,
        output rf_rs1_addr, rf_rs2_addr, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_rd_addr, ex_imm, ex_ctrl, ex_mem_read, stall_id, perf_stall_cnt
    );

endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// rtl/id_ex_stage_operand_bypass.sv - write-through bypass of same-cycle writeback data onto one source operand
module operand_bypass
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  reg_addr_t        rs_addr_i,
    input  logic [WIDTH-1:0] rf_data_i,
    input  logic             wb_reg_write_i,
    input  reg_addr_t        wb_rd_addr_i,
    input  logic [WIDTH-1:0] wb_data_i,
    output logic [WIDTH-1:0] operand_o
);

    // The register file commits on the edge, so in the write cycle it still returns the old value.
    always_comb begin
        operand_o = rf_data_i;
        if (wb_reg_write_i && (wb_rd_addr_i != X0) && (wb_rd_addr_i == rs_addr_i)) begin
            operand_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand bypass, load-use bubble and stall counter
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    logic              ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0]  ex_pc_q, ex_pc_d;
    logic [WIDTH-1:0]  ex_rs1_q, ex_rs1_d;
    logic [WIDTH-1:0]  ex_rs2_q, ex_rs2_d;
    reg_addr_t         ex_rd_q, ex_rd_d;
    logic [WIDTH-1:0]  ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [31:0]       perf_stall_cnt_q, perf_stall_cnt_d;

    logic [WIDTH-1:0]  rs1_operand;
    logic [WIDTH-1:0]  rs2_operand;
    logic              hazard;
    logic              stall_id;

    assign bus.rf_rs1_addr = bus.id_rs1_addr;
    assign bus.rf_rs2_addr = bus.id_rs2_addr;

    operand_bypass #(.WIDTH(WIDTH)) u_bypass_rs1 (
        .rs_addr_i      (bus.id_rs1_addr),
        .rf_data_i      (bus.rf_rs1_data),
        .wb_reg_write_i (bus.wb_regWrite),
        .wb_rd_addr_i   (bus.wb_rd_addr),
        .wb_data_i      (bus.wb_write_data),
        .operand_o      (rs1_operand)
    );

    operand_bypass #(.WIDTH(WIDTH)) u_bypass_rs2 (
        .rs_addr_i      (bus.id_rs2_addr),
        .rf_data_i      (bus.rf_rs2_data),
        .wb_reg_write_i (bus.wb_regWrite),
        .wb_rd_addr_i   (bus.wb_rd_addr),
        .wb_data_i      (bus.wb_write_data),
        .operand_o      (rs2_operand)
    );

    // A load in EX cannot supply its result until WB, so a dependent instruction waits one cycle.
    assign hazard = ex_valid_q && ex_mem_read_q && (ex_rd_q != X0) && bus.id_valid &&
                    ((bus.id_uses_rs1 && (ex_rd_q == bus.id_rs1_addr)) ||
                     (bus.id_uses_rs2 && (ex_rd_q == bus.id_rs2_addr)));

    assign stall_id = bus.ex_stall || (hazard && !bus.flush);

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_imm_d      = ex_imm_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_mem_read_d = ex_mem_read_q;

        // A stalled execute keeps flush high until it unstalls, so holding takes priority.
        if (bus.ex_stall) begin
            ex_valid_d = ex_valid_q;
        end else if (bus.flush || hazard) begin
            ex_valid_d    = 1'b0;
            ex_pc_d       = '0;
            ex_rs1_d      = '0;
            ex_rs2_d      = '0;
            ex_rd_d       = X0;
            ex_imm_d      = '0;
            ex_ctrl_d     = '0;
            ex_mem_read_d = 1'b0;
        end else begin
            ex_valid_d    = bus.id_valid;
            ex_pc_d       = bus.id_pc;
            ex_rs1_d      = rs1_operand;
            ex_rs2_d      = rs2_operand;
            ex_rd_d       = bus.id_rd_addr;
            ex_imm_d      = bus.id_imm;
            ex_ctrl_d     = bus.id_ctrl;
            ex_mem_read_d = bus.id_mem_read && bus.id_valid;
        end

        perf_stall_cnt_d = stall_id ? (perf_stall_cnt_q + 32'd1) : perf_stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q       <= 1'b0;
            ex_pc_q          <= '0;
            ex_rs1_q         <= '0;
            ex_rs2_q         <= '0;
            ex_rd_q          <= X0;
            ex_imm_q         <= '0;
            ex_ctrl_q        <= '0;
            ex_mem_read_q    <= 1'b0;
            perf_stall_cnt_q <= '0;
        end else begin
            ex_valid_q       <= ex_valid_d;
            ex_pc_q          <= ex_pc_d;
            ex_rs1_q         <= ex_rs1_d;
            ex_rs2_q         <= ex_rs2_d;
            ex_rd_q          <= ex_rd_d;
            ex_imm_q         <= ex_imm_d;
            ex_ctrl_q        <= ex_ctrl_d;
            ex_mem_read_q    <= ex_mem_read_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.ex_rs1_data    = ex_rs1_q;
    assign bus.ex_rs2_data    = ex_rs2_q;
    assign bus.ex_rd_addr     = ex_rd_q;
    assign bus.ex_imm         = ex_imm_q;
    assign bus.ex_ctrl        = ex_ctrl_q;
    assign bus.ex_mem_read    = ex_mem_read_q;
    assign bus.stall_id       = stall_id;
    assign bus.perf_stall_cnt = perf_stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed vector bench for id_ex_stage
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst;

    id_ex_stage_if #(.WIDTH(32)) bus ();

    id_ex_stage #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id_valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, mr;
        logic [31:0] rf1, rf2;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        stall, flush;
        logic        e_stall_id, e_valid;
        logic [31:0] e_pc, e_rs1, e_rs2;
        logic [4:0]  e_rd;
        logic        e_mr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[16];
    int   n_app;
    int   n_err;

    function automatic vec_t mk(int v, int pc, int rs1, int rs2, int rd, int u1, int u2, int mr,
                                int rf1, int rf2, int we, int wrd, int wdata, int st, int fl,
                                int es, int ev, int epc, int ers1, int ers2, int erd, int emr, int ecnt);
        vec_t r;
        r.id_valid = v[0];   r.pc = pc;          r.rs1 = rs1[4:0];  r.rs2 = rs2[4:0];
        r.rd = rd[4:0];      r.u1 = u1[0];       r.u2 = u2[0];      r.mr = mr[0];
        r.rf1 = rf1;         r.rf2 = rf2;        r.we = we[0];      r.wrd = wrd[4:0];
        r.wdata = wdata;     r.stall = st[0];    r.flush = fl[0];
        r.e_stall_id = es[0]; r.e_valid = ev[0]; r.e_pc = epc;      r.e_rs1 = ers1;
        r.e_rs2 = ers2;      r.e_rd = erd[4:0];  r.e_mr = emr[0];   r.e_cnt = ecnt;
        return r;
    endfunction

    // imm and ctrl are derived from pc so bubbles (pc 0) expect 0 in both
    function automatic logic [31:0] imm_of(logic [31:0] pc);
        return pc << 4;
    endfunction

    function automatic logic [15:0] ctrl_of(logic [31:0] pc);
        return {pc[7:0], pc[7:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.id_valid = 1'b0;     bus.id_pc = '0;          bus.id_rs1_addr = '0;
        bus.id_rs2_addr = '0;    bus.id_rd_addr = '0;     bus.id_uses_rs1 = 1'b0;
        bus.id_uses_rs2 = 1'b0;  bus.id_mem_read = 1'b0;  bus.id_imm = '0;
        bus.id_ctrl = '0;        bus.rf_rs1_data = '0;    bus.rf_rs2_data = '0;
        bus.wb_regWrite = 1'b0;  bus.wb_rd_addr = '0;     bus.wb_write_data = '0;
        bus.ex_stall = 1'b0;     bus.flush = 1'b0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " ex_valid"}, {31'd0, bus.ex_valid}, 32'd0);
        chk({tag, " ex_pc"}, bus.ex_pc, 32'd0);
        chk({tag, " ex_rs1"}, bus.ex_rs1_data, 32'd0);
        chk({tag, " ex_rs2"}, bus.ex_rs2_data, 32'd0);
        chk({tag, " ex_rd"}, {27'd0, bus.ex_rd_addr}, 32'd0);
        chk({tag, " ex_imm"}, bus.ex_imm, 32'd0);
        chk({tag, " ex_ctrl"}, {16'd0, bus.ex_ctrl}, 32'd0);
        chk({tag, " ex_mem_read"}, {31'd0, bus.ex_mem_read}, 32'd0);
        chk({tag, " perf"}, bus.perf_stall_cnt, 32'd0);
    endtask

    initial begin
        n_app = 0;
        n_err = 0;

        //         v  pc      rs1 rs2 rd  u1 u2 mr rf1    rf2   we wrd wdata    st fl | sid ev epc     ers1    ers2    erd emr cnt
        vecs[0]  = mk(1, 'h100, 3,  4,  1,  1, 1, 0, 'h11,  'h22, 0, 0, 0,       0, 0,  0,  1, 'h100, 'h11,   'h22,   1,  0,  0);
        vecs[1]  = mk(1, 'h104, 2,  5,  6,  1, 1, 0, 'h33,  0,    1, 5, 'hDEAD,  0, 0,  0,  1, 'h104, 'h33,   'hDEAD, 6,  0,  0);
        vecs[2]  = mk(1, 'h108, 1,  0,  8,  1, 1, 0, 'h44,  0,    1, 0, 'hBEEF,  0, 0,  0,  1, 'h108, 'h44,   0,      8,  0,  0);
        vecs[3]  = mk(1, 'h10C, 1,  2,  7,  1, 1, 1, 1,     2,    0, 0, 0,       0, 0,  0,  1, 'h10C, 1,      2,      7,  1,  0);
        vecs[4]  = mk(1, 'h110, 7,  0,  10, 1, 0, 0, 'h70,  0,    0, 0, 0,       0, 0,  1,  0, 0,     0,      0,      0,  0,  1);
        vecs[5]  = mk(1, 'h110, 7,  0,  10, 1, 0, 0, 'h70,  0,    1, 7, 'h777,   0, 0,  0,  1, 'h110, 'h777,  0,      10, 0,  1);
        vecs[6]  = mk(1, 'h114, 0,  0,  7,  0, 0, 1, 0,     0,    0, 0, 0,       0, 0,  0,  1, 'h114, 0,      0,      7,  1,  1);
        vecs[7]  = mk(1, 'h118, 7,  6,  7,  0, 0, 1, 5,     6,    0, 0, 0,       0, 0,  0,  1, 'h118, 5,      6,      7,  1,  1);
        vecs[8]  = mk(1, 'h11C, 0,  7,  12, 0, 1, 0, 0,     0,    0, 0, 0,       0, 1,  0,  0, 0,     0,      0,      0,  0,  1);
        vecs[9]  = mk(1, 'h200, 3,  4,  13, 1, 1, 0, 'hAA,  'hBB, 0, 0, 0,       0, 0,  0,  1, 'h200, 'hAA,   'hBB,   13, 0,  1);
        vecs[10] = mk(1, 'h204, 5,  6,  14, 1, 1, 1, 1,     2,    0, 0, 0,       1, 0,  1,  1, 'h200, 'hAA,   'hBB,   13, 0,  2);
        vecs[11] = mk(1, 'h208, 8,  9,  15, 1, 1, 0, 3,     4,    1, 8, 'h55,    1, 1,  1,  1, 'h200, 'hAA,   'hBB,   13, 0,  3);
        vecs[12] = mk(1, 'h20C, 10, 11, 16, 1, 1, 0, 5,     6,    0, 0, 0,       1, 1,  1,  1, 'h200, 'hAA,   'hBB,   13, 0,  4);
        vecs[13] = mk(1, 'h210, 5,  6,  17, 1, 1, 0, 1,     2,    0, 0, 0,       0, 1,  0,  0, 0,     0,      0,      0,  0,  4);
        vecs[14] = mk(1, 'h300, 9,  0,  17, 1, 0, 0, 'h99,  0,    0, 0, 0,       0, 0,  0,  1, 'h300, 'h99,   0,      17, 0,  4);
        vecs[15] = mk(0, 'h304, 1,  2,  18, 1, 1, 1, 5,     6,    0, 0, 0,       0, 0,  0,  0, 'h304, 5,      6,      18, 0,  4);

        // reset with execute stalled: stall_id still follows ex_stall, state stays cleared
        set_idle();
        rst = 1'b1;
        bus.ex_stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset stall_id", {31'd0, bus.stall_id}, 32'd1);
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        bus.ex_stall = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.id_valid = vecs[i].id_valid;  bus.id_pc = vecs[i].pc;
            bus.id_rs1_addr = vecs[i].rs1;    bus.id_rs2_addr = vecs[i].rs2;
            bus.id_rd_addr = vecs[i].rd;      bus.id_uses_rs1 = vecs[i].u1;
            bus.id_uses_rs2 = vecs[i].u2;     bus.id_mem_read = vecs[i].mr;
            bus.id_imm = imm_of(vecs[i].pc);  bus.id_ctrl = ctrl_of(vecs[i].pc);
            bus.rf_rs1_data = vecs[i].rf1;    bus.rf_rs2_data = vecs[i].rf2;
            bus.wb_regWrite = vecs[i].we;     bus.wb_rd_addr = vecs[i].wrd;
            bus.wb_write_data = vecs[i].wdata;
            bus.ex_stall = vecs[i].stall;     bus.flush = vecs[i].flush;
            #1;
            chk($sformatf("v%0d stall_id", i), {31'd0, bus.stall_id}, {31'd0, vecs[i].e_stall_id});
            chk($sformatf("v%0d rf_rs1_addr", i), {27'd0, bus.rf_rs1_addr}, {27'd0, vecs[i].rs1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d ex_pc", i), bus.ex_pc, vecs[i].e_pc);
            chk($sformatf("v%0d ex_rs1", i), bus.ex_rs1_data, vecs[i].e_rs1);
            chk($sformatf("v%0d ex_rs2", i), bus.ex_rs2_data, vecs[i].e_rs2);
            chk($sformatf("v%0d ex_rd", i), {27'd0, bus.ex_rd_addr}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d ex_mem_read", i), {31'd0, bus.ex_mem_read}, {31'd0, vecs[i].e_mr});
            chk($sformatf("v%0d ex_imm", i), bus.ex_imm, imm_of(vecs[i].e_pc));
            chk($sformatf("v%0d ex_ctrl", i), {16'd0, bus.ex_ctrl}, {16'd0, ctrl_of(vecs[i].e_pc)});
            chk($sformatf("v%0d perf", i), bus.perf_stall_cnt, vecs[i].e_cnt);
        end

        // mid-operation reset clears loaded state and counter
        @(negedge clk);
        set_idle();
        bus.id_valid = 1'b1;
        bus.id_pc = 32'h400;
        bus.ex_stall = 1'b1;
        rst = 1'b1;
        #1;
        chk("midreset stall_id", {31'd0, bus.stall_id}, 32'd1);
        @(posedge clk);
        #1;
        chk_all_zero("midreset");

        // counter wrap from all ones
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        force dut.perf_stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_stall_cnt_q;
        chk("wrap preload", bus.perf_stall_cnt, 32'hFFFF_FFFF);
        bus.ex_stall = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap to zero", bus.perf_stall_cnt, 32'd0);
        @(negedge clk);
        bus.ex_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("no stall holds count", bus.perf_stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage sitting directly downstream of `register_file`. It drives the two read addresses, merges same-cycle writeback data into the operands through a write-through bypass, detects load-use hazards and inserts a one-cycle bubble, and holds the ID/EX pipeline register for execute. It also honours execute back-pressure and branch flush, and keeps a stall-cycle performance counter.

## Interface
- `WIDTH`, 32, datapath width.
- `CTRL_W`, 16, width of the opaque decoded control bundle.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_pc` in WIDTH: instruction PC.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr` in 5 each: decoded register fields.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: operand actually consumed.
- `id_mem_read` in 1: instruction is a load.
- `id_imm` in WIDTH: sign-extended immediate.
- `id_ctrl` in CTRL_W: control bundle, passed through unchanged.
- `rf_rs1_addr`, `rf_rs2_addr` out 5 each: wired straight to the register file read ports (equal to `id_rs*_addr`).
- `rf_rs1_data`, `rf_rs2_data` in WIDTH: register file read data.
- `wb_regWrite` in 1, `wb_rd_addr` in 5, `wb_write_data` in WIDTH: the same writeback bus that drives the register file.
- `ex_stall` in 1: execute cannot accept a new instruction.
- `flush` in 1: branch/jump resolved taken in execute.
- `ex_valid` out 1, `ex_pc` out WIDTH, `ex_rs1_data`, `ex_rs2_data` out WIDTH, `ex_rd_addr` out 5, `ex_imm` out WIDTH, `ex_ctrl` out CTRL_W, `ex_mem_read` out 1: registered ID/EX contents.
- `stall_id` out 1: freeze PC and IF/ID this cycle (combinational).
- `perf_stall_cnt` out 32: count of cycles in which `stall_id` was asserted.

## Operation
**Bypass**
- For each source rsN, the operand is `wb_write_data` when `wb_regWrite` is high, `wb_rd_addr` ≠ 0 and `wb_rd_addr` = `id_rsN_addr`. Otherwise it is `rf_rsN_data`.
- The bypass is needed because the register file writes on the edge and so returns the old value in the write cycle.
- Address 0 is never bypassed, so operand x0 is always 0.

**Hazard**
- `hazard` = `ex_valid` & `ex_mem_read` & (`ex_rd_addr` ≠ 0) & `id_valid` & ((`id_uses_rs1` & `ex_rd_addr` = `id_rs1_addr`) | (`id_uses_rs2` & `ex_rd_addr` = `id_rs2_addr`)).

**Stall output**
- `stall_id` = `ex_stall` | (`hazard` & !`flush`).

**Register update priority at each edge**
1. `rst`: all `ex_*` outputs go to 0 and `perf_stall_cnt` goes to 0.
2. `ex_stall`: hold every `ex_*` field; `flush` is ignored. Execute keeps `flush` asserted until it is no longer stalled.
3. `flush`: `ex_valid` ← 0 and `ex_mem_read` ← 0; data fields are don't-care but are cleared to 0.
4. `hazard`: insert a bubble; same clearing as for `flush`.
5. Otherwise: load all fields from the ID inputs and the bypassed operands. `ex_valid` ← `id_valid`; `ex_mem_read` ← `id_mem_read` & `id_valid`.

**Counter and scope**
- `perf_stall_cnt` increments when `stall_id` = 1 and `rst` = 0. It wraps modulo 2^32.
- Forwarding from MEM/WB into execute is out of scope; this block only guarantees register-file coherence at capture.

## Timing
- Capture latency is 1 cycle: ID inputs in cycle n appear on `ex_*` in cycle n+1.
- A load-use hazard costs exactly one bubble. In the following cycle the load has left EX, `hazard` drops, and the held ID instruction is captured. Its operand comes through the bypass if the load reaches WB in that same cycle.
- `stall_id`, `rf_rs*_addr` and the bypass are combinational, with no added latency.
- Reset is asserted mid-operation: the next edge clears everything; `stall_id` still reflects `ex_stall` during reset.
- `flush` and `hazard` in the same cycle: `flush` wins and `stall_id` = `ex_stall`.

## Structure
- Shared package `cpu_pkg` holds `CTRL_W`, the register-index width (5) and the `x0` constant. Keep `WIDTH` as a parameter.
- One sub-module, `operand_bypass`: a combinational mux (address, rf data, wb bus → operand). It is instantiated twice.
- Hazard detection and the counter stay inline.

## Test plan
- Reset, then `id_valid`=1, rs1=3, `rf_rs1_data`=0x11 → next cycle `ex_valid`=1, `ex_rs1_data`=0x11, and all outputs were 0 during reset.
- WB writes x5=0xDEAD in the same cycle that ID reads rs2=5 with `rf_rs2_data`=0x0 → `ex_rs2_data`=0xDEAD. Repeat with rd=0 → operand 0, no bypass.
- Load to x7 sits in EX while ID has `id_uses_rs1`=1, rs1=7 → `stall_id`=1 for one cycle, one bubble (`ex_valid`=0), the instruction is captured the next cycle, and `perf_stall_cnt`=1. Repeat with `id_uses_rs1`=0 → no stall.
- `flush`=1 together with the load-use hazard → `ex_valid`=0, `stall_id`=0, counter unchanged.
- `ex_stall`=1 for 3 cycles with changing ID inputs → `ex_*` held constant, `stall_id`=1, counter +3. Asserting `flush` during the stall has no effect until `ex_stall` drops.
- Preload `perf_stall_cnt` to 0xFFFFFFFF via a stall sequence (or force) → one more stall cycle wraps it to 0.
